// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM states and opcode classification helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // MUL is treated as signed; its low word is identical either way.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage (master) and the
// multiply/divide unit (slave), including pipeline flush and busy.
interface muldiv_if #(parameter int W = 32);
  logic         iflush;
  logic         ivalid;
  logic         oready;
  logic [2:0]   iop;
  logic [W-1:0] isrc_a;
  logic [W-1:0] isrc_b;
  logic         ovalid;
  logic         iready;
  logic [W-1:0] oresult;
  logic         obusy;

  modport master (
    output iflush, ivalid, iop, isrc_a, isrc_b, iready,
    input  oready, ovalid, oresult, obusy
  );

  modport slave (
    input  iflush, ivalid, iop, isrc_a, isrc_b, iready,
    output oready, ovalid, oresult, obusy
  );
endinterface

// File: rtl/muldiv_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift the next dividend bit into the remainder and subtract if it fits.
module muldiv_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic       fits;

  assign shifted = {rem_in, quo_in[W-1]};
  assign fits    = shifted >= {1'b0, divisor};

  // quo_in doubles as the dividend shift register; quotient bits fill from the LSB.
  always_comb begin
    rem_out = shifted[W-1:0];
    quo_out = {quo_in[W-2:0], 1'b0};
    if (fits) begin
      rem_out = W'(shifted - {1'b0, divisor});
      quo_out = {quo_in[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshake and flush.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_CNT_WIDTH  = $clog2(MP_DATA_WIDTH) + 1
) (
  input  logic      iclk,
  input  logic      irst_n,
  muldiv_if.slave   bus
);

  localparam int W = MP_DATA_WIDTH;

  state_t              state_reg;
  logic [2:0]          op_reg;
  logic [MP_CNT_WIDTH-1:0] cnt_reg;
  logic [2*W-1:0]      acc_reg;
  logic [2*W-1:0]      mcand_reg;
  logic [W-1:0]        mplier_reg;
  logic [W-1:0]        rem_reg;
  logic [W-1:0]        quo_reg;
  logic [W-1:0]        divisor_reg;
  logic [W-1:0]        result_reg;
  logic                neg_res_reg;
  logic                neg_rem_reg;

  logic           sign_a, sign_b, div_zero, div_ovf;
  logic [W-1:0]   abs_a, abs_b;
  logic [2*W-1:0] acc_next, prod_fix;
  logic [W-1:0]   rem_step, quo_step, quo_fix, rem_fix;
  logic           last_iter, mul_last;

  assign sign_a   = is_signed_a(bus.iop) & bus.isrc_a[W-1];
  assign sign_b   = is_signed_b(bus.iop) & bus.isrc_b[W-1];
  assign abs_a    = sign_a ? -bus.isrc_a : bus.isrc_a;
  assign abs_b    = sign_b ? -bus.isrc_b : bus.isrc_b;
  assign div_zero = (bus.isrc_b == '0);
  assign div_ovf  = is_div(bus.iop) && is_signed_b(bus.iop) &&
                    (bus.isrc_a == {1'b1, {(W-1){1'b0}}}) && (bus.isrc_b == '1);

  assign acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last_iter = (cnt_reg == MP_CNT_WIDTH'(W - 1));

`ifdef MULDIV_EARLY_OUT_EN
  // Finish on the edge that consumes the last set multiplier bit.
  assign mul_last = last_iter | (mplier_reg[W-1:1] == '0);
`else
  assign mul_last = last_iter;
`endif

  assign prod_fix = neg_res_reg ? -acc_next : acc_next;
  assign quo_fix  = neg_res_reg ? -quo_step : quo_step;
  assign rem_fix  = neg_rem_reg ? -rem_step : rem_step;

  muldiv_div_step #(.W(W)) u_div_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (divisor_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      result_reg  <= '0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
    end else if (bus.iflush) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.ivalid) begin
            op_reg      <= bus.iop;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= {{W{1'b0}}, abs_a};
            mplier_reg  <= abs_b;
            rem_reg     <= '0;
            quo_reg     <= abs_a;
            divisor_reg <= abs_b;
            neg_res_reg <= sign_a ^ sign_b;
            neg_rem_reg <= sign_a;
            // Divide corner cases resolve at accept without iterating.
            if (!is_div(bus.iop)) begin
              state_reg <= ST_MUL;
            end else if (div_zero) begin
              result_reg <= is_rem(bus.iop) ? bus.isrc_a : '1;
              state_reg  <= ST_DONE;
            end else if (div_ovf) begin
              result_reg <= is_rem(bus.iop) ? '0 : bus.isrc_a;
              state_reg  <= ST_DONE;
            end else begin
              state_reg <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + MP_CNT_WIDTH'(1);
          if (mul_last) begin
            result_reg <= (op_reg == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
            state_reg  <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + MP_CNT_WIDTH'(1);
          if (last_iter) begin
            result_reg <= is_rem(op_reg) ? rem_fix : quo_fix;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.iready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the state flop.
  assign bus.oready  = (state_reg == ST_IDLE);
  assign bus.ovalid  = (state_reg == ST_DONE);
  assign bus.obusy   = (state_reg != ST_IDLE);
  assign bus.oresult = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (W=32) with a result scoreboard.
// Latency is counted in clock edges from the accept edge to the edge that raises ovalid.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_if #(.W(32)) bus();

  muldiv_unit #(.MP_DATA_WIDTH(32)) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected multiply latency from the multiplier magnitude.
  function automatic int mul_lat(input logic [31:0] abs_b);
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++) if (abs_b[i]) msb = i;
    return EARLY ? msb + 1 : 32;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expv, input int exp_lat,
                       input int hold);
    int lat;
    logic busy_ok, stable_ok;
    logic [31:0] held;
    check({tag, " ready"}, bus.oready, 1);
    bus.iop = op; bus.isrc_a = a; bus.isrc_b = b;
    bus.ivalid = 1'b1; bus.iready = (hold == 0);
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
    bus.isrc_a = $urandom; bus.isrc_b = $urandom; bus.iop = 3'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!bus.ovalid && lat < 200) begin
      if (!bus.obusy || bus.oready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " result"}, bus.oresult, exp_q.pop_front());
    if (hold > 0) begin
      stable_ok = 1'b1; held = bus.oresult;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!bus.ovalid || bus.oresult !== held || bus.oready) stable_ok = 1'b0;
      end
      check({tag, " hold stable"}, stable_ok, 1);
      bus.iready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " retire"}, {bus.oready, bus.ovalid, bus.obusy}, 3'b100);
    $display("[TB] %s op=%0d a=%h b=%h result=%h lat=%0d", tag, op, a, b, held, lat);
  endtask

  initial begin
    logic seen;
    bus.iflush = 1'b0; bus.ivalid = 1'b0; bus.iready = 1'b1;
    bus.iop = '0; bus.isrc_a = '0; bus.isrc_b = '0;
    repeat (3) @(posedge clk); #1;
    check("reset outputs", {bus.oready, bus.ovalid, bus.obusy}, 3'b100);
    check("reset result", bus.oresult, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, mul_lat(32'd3), 0);
    do_op("MULH min*min", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, mul_lat(32'h80000000), 0);
    do_op("MULHU max*max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, mul_lat(32'hFFFFFFFF), 0);
    do_op("MULHSU -1*max", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, mul_lat(32'hFFFFFFFF), 0);
    do_op("MUL early", OP_MUL, 32'h12345678, 32'd3, 32'h369D0368, mul_lat(32'd3), 0);
    do_op("MUL by zero", OP_MUL, 32'd5, 32'd0, 32'd0, mul_lat(32'd0), 0);
    do_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, 0);
    do_op("REM -7/2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, 0);
    do_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);
    do_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 32, 0);
    // Shortcut ops raise ovalid on the accept edge itself.
    do_op("DIV 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0);
    do_op("REM 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 0, 0);
    do_op("DIVU 9/0", OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 0, 0);
    do_op("REMU 9/0", OP_REMU, 32'd9, 32'd0, 32'd9, 0, 0);
    do_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    do_op("REM ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, 0);
    do_op("DIVU backpressure", OP_DIVU, 32'd1000, 32'd7, 32'd142, 32, 10);

    // Flush during the tenth divide iteration.
    bus.iop = OP_DIVU; bus.isrc_a = 32'd1000; bus.isrc_b = 32'd3;
    bus.ivalid = 1'b1; bus.iready = 1'b1;
    exp_q.push_back(32'd333);
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("flush busy before", bus.obusy, 1);
    bus.iflush = 1'b1;
    @(posedge clk); #1;
    bus.iflush = 1'b0;
    void'(exp_q.pop_front());
    check("flush idle", {bus.oready, bus.ovalid, bus.obusy}, 3'b100);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.ovalid) seen = 1'b1;
    end
    check("flush no ovalid", seen, 0);
    $display("[TB] flush DIVU 1000/3 at iteration 10 ovalid_seen=%0b", seen);

    // Flush together with a request in IDLE: nothing is accepted.
    bus.iop = OP_MUL; bus.isrc_a = 32'd3; bus.isrc_b = 32'd4;
    bus.ivalid = 1'b1; bus.iflush = 1'b1;
    @(posedge clk); #1;
    bus.ivalid = 1'b0; bus.iflush = 1'b0;
    check("flush blocks accept", {bus.oready, bus.ovalid, bus.obusy}, 3'b100);
    $display("[TB] flush+ivalid in IDLE busy=%0b", bus.obusy);

    do_op("MUL 6*7", OP_MUL, 32'd6, 32'd7, 32'd42, mul_lat(32'd7), 0);

    // Asynchronous reset in the middle of a multiply.
    bus.iop = OP_MUL; bus.isrc_a = 32'h12345678; bus.isrc_b = 32'hFFFFFFFF;
    bus.ivalid = 1'b1;
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("mid-MUL busy", bus.obusy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {bus.oready, bus.ovalid, bus.obusy}, 3'b100);
    check("async reset result", bus.oresult, 32'h0);
    $display("[TB] async reset mid-MUL result=%h", bus.oresult);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("DIVU after reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 32, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
